// File: rtl/li_fifo_reader.sv
// Adapts a fixed-latency non-showahead FIFO read port to a valid/ready stream with
// credit-based prefetch into a small first-word-fall-through skid buffer.
module li_fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_deq,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
);

  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int PW        = $clog2(BUF_DEPTH);
  localparam int CW        = $clog2(BUF_DEPTH + 1);

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic                  capture;
  logic                  pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign capture    = vld_q[RD_LATENCY-1];
  assign o_valid    = (count_q != '0);
  assign o_data     = mem_q[rd_ptr_q];
  assign pop        = o_valid && i_ready;
  // A pop in this cycle frees a slot, so it may fund a read even with zero credit.
  assign o_fifo_deq = reset && !i_fifo_empty && ((credit_q != '0) || pop);

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = o_fifo_deq;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    wr_ptr_d = capture ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (capture && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !capture) begin
      count_d = count_q - CW'(1);
    end
    credit_d = credit_q;
    if (o_fifo_deq && !pop) begin
      credit_d = credit_q - CW'(1);
    end else if (pop && !o_fifo_deq) begin
      credit_d = credit_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= CW'(BUF_DEPTH);
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
      if (capture) begin
        mem_q[wr_ptr_q] <= i_fifo_data;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(capture && (count_q == CW'(BUF_DEPTH)) && !pop))
    else $error("li_fifo_reader: capture into a full buffer");

endmodule

// File: tb/tb_li_fifo_reader.sv
// Scoreboard bench: instance 0 has RD_LATENCY=2, instance 1 has RD_LATENCY=1; each
// has an upstream FIFO model with matching read latency.
module tb_li_fifo_reader;

  logic             clk = 1'b0;
  logic [1:0]       rst_n = 2'b00;
  logic [1:0]       ordy = 2'b11;
  logic [1:0]       deq;
  logic [1:0]       ovld;
  logic [1:0][15:0] odata;
  int               n_tests = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = (g == 0) ? 2 : 1;
    logic [15:0] fq[$];
    logic [15:0] exq[$];
    logic [15:0] pipe [L];
    logic [15:0] fdata;
    logic        fempty;
    int          ndeq = 0;
    logic        hold_q = 1'b0;
    logic [15:0] hold_dat = '0;

    li_fifo_reader #(.DATA_WIDTH(16), .RD_LATENCY(L)) dut (
      .clock       (clk),
      .reset       (rst_n[g]),
      .i_fifo_data (fdata),
      .i_fifo_empty(fempty),
      .o_fifo_deq  (deq[g]),
      .o_data      (odata[g]),
      .o_valid     (ovld[g]),
      .i_ready     (ordy[g])
    );

    // Upstream FIFO: a read requested in cycle t shows its word only in cycle t+L.
    always @(posedge clk) begin
      for (int k = L - 1; k > 0; k--) pipe[k] = pipe[k-1];
      if (deq[g] && fq.size() > 0) pipe[0] = fq.pop_front();
      else pipe[0] = 16'hDEAD;
      fdata  <= pipe[L-1];
      fempty <= (fq.size() == 0);
      if (rst_n[g] && deq[g]) ndeq <= ndeq + 1;
    end

    always @(negedge clk) begin
      if (!rst_n[g]) begin
        hold_q = 1'b0;
      end else begin
        if (hold_q) begin
          check("hold_vld", ovld[g], 1'b1);
          check("hold_dat", odata[g], hold_dat);
        end
        if (ovld[g] && ordy[g]) begin
          if (exq.size() == 0) check("mon_extra_vld", ovld[g], 1'b0);
          else check("mon_data", odata[g], exq.pop_front());
        end
        hold_q   = ovld[g] && !ordy[g];
        hold_dat = odata[g];
      end
    end
  end

  task automatic push(input int d, input logic [15:0] w, input bit ex);
    if (d == 0) begin
      u[0].fq.push_back(w);
      if (ex) u[0].exq.push_back(w);
    end else begin
      u[1].fq.push_back(w);
      if (ex) u[1].exq.push_back(w);
    end
  endtask

  function automatic int ndeq_of(input int d);
    return (d == 0) ? u[0].ndeq : u[1].ndeq;
  endfunction

  function automatic int exq_n(input int d);
    return (d == 0) ? u[0].exq.size() : u[1].exq.size();
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_deq(input int d);
    for (int i = 0; i < 20; i++) begin
      nxt();
      #1;
      if (deq[d]) break;
    end
    check("deq_seen", deq[d], 1'b1);
  endtask

  int n0;

  initial begin
    // Reset with a non-empty FIFO
    push(0, 16'hA5A5, 1'b1);
    nxt();
    for (int i = 0; i < 3; i++) begin
      nxt();
      #1;
      check("rst_deq", deq[0], 1'b0);
      check("rst_vld", ovld[0], 1'b0);
      check("rst_dat", odata[0], 16'h0);
    end
    nxt();
    rst_n[0] = 1'b1;
    #1;
    check("rel_vld", ovld[0], 1'b0);
    check("rel_dat", odata[0], 16'h0);
    check("rel_deq", deq[0], 1'b1);
    repeat (6) nxt();

    // Single word: valid exactly RD_LATENCY+1 cycles after the read, for one cycle
    push(0, 16'h1234, 1'b1);
    wait_deq(0);
    for (int k = 1; k <= 4; k++) begin
      nxt();
      #1;
      check("single_vld", ovld[0], (k == 3));
      check("single_deq", deq[0], 1'b0);
    end

    // Streaming 8 words with no bubbles
    for (int w = 1; w <= 8; w++) push(0, 16'(w), 1'b1);
    wait_deq(0);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        nxt();
        #1;
      end
      check("str_deq", deq[0], (k < 8));
      check("str_vld", ovld[0], (k >= 3 && k <= 10));
    end

    // Backpressure: credits stop reads at buffer depth
    ordy[0] = 1'b0;
    n0 = ndeq_of(0);
    for (int w = 1; w <= 6; w++) push(0, 16'h0B00 + 16'(w), 1'b1);
    repeat (10) nxt();
    #1;
    check("bp_ndeq", ndeq_of(0) - n0, 3);
    check("bp_vld", ovld[0], 1'b1);
    check("bp_dat", odata[0], 16'h0B01);
    check("bp_deq", deq[0], 1'b0);
    nxt();
    ordy[0] = 1'b1;
    #1;
    check("bp_resume_deq", deq[0], 1'b1);
    repeat (12) nxt();
    #1;
    check("bp_ndeq_total", ndeq_of(0) - n0, 6);
    check("bp_drained", exq_n(0), 0);

    // Reset mid-stream after two reads; their data must never appear
    for (int w = 1; w <= 5; w++) push(0, 16'h0C00 + 16'(w), 1'b0);
    wait_deq(0);
    nxt();
    #1;
    check("mr_deq2", deq[0], 1'b1);
    nxt();
    rst_n[0] = 1'b0;
    u[0].fq.delete();
    #1;
    check("mr_deq_rst", deq[0], 1'b0);
    nxt();
    rst_n[0] = 1'b1;
    #1;
    check("mr_vld", ovld[0], 1'b0);
    for (int k = 0; k < 6; k++) begin
      nxt();
      #1;
      check("mr_vld_after", ovld[0], 1'b0);
    end
    ordy[0] = 1'b0;
    n0 = ndeq_of(0);
    for (int w = 1; w <= 4; w++) push(0, 16'h0D00 + 16'(w), 1'b1);
    repeat (8) nxt();
    #1;
    check("mr_credit", ndeq_of(0) - n0, 3);
    ordy[0] = 1'b1;
    repeat (10) nxt();
    #1;
    check("mr_drained", exq_n(0), 0);

    // RD_LATENCY=1 instance
    nxt();
    rst_n[1] = 1'b1;
    #1;
    check("l1_rel_vld", ovld[1], 1'b0);
    check("l1_rel_dat", odata[1], 16'h0);
    for (int w = 1; w <= 8; w++) push(1, 16'h0100 + 16'(w), 1'b1);
    wait_deq(1);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin
        nxt();
        #1;
      end
      check("l1_str_deq", deq[1], (k < 8));
      check("l1_str_vld", ovld[1], (k >= 2 && k <= 9));
    end
    for (int w = 0; w < 24; w++) push(1, 16'h2000 + 16'(w), 1'b1);
    for (int k = 0; k < 80; k++) begin
      nxt();
      ordy[1] = 1'($urandom_range(0, 1));
    end
    nxt();
    ordy[1] = 1'b1;
    repeat (10) nxt();
    #1;
    check("l1_rand_drained", exq_n(1), 0);
    check("l1_rand_ndeq", ndeq_of(1), 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
